// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the instruction fetch unit, instruction memory,
// the redirect source and the instruction-register/decode consumer.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              busy;

  // Fetch unit side: masters the memory bus and feeds the consumer.
  modport master (
    output mem_req, mem_addr, instr_valid, instr_out, instr_pc, busy,
    input  mem_ack, mem_rdata, redirect, redirect_pc, instr_ready
  );

  // Environment side: memory, redirect source and consumer.
  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_out, instr_pc, busy,
    output mem_ack, mem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction prefetcher: word reads into a small FIFO, PC-tagged
// output handshake, and redirects that may have to drain a pending read.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    FETCH = 1'b0,
    KILL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tgt_pc;
  logic [ADDR_W-1:0] redir_al;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       buf_instr [DEPTH];
  logic [ADDR_W-1:0] buf_pc    [DEPTH];
  logic [31:0]       hold_instr;
  logic [ADDR_W-1:0] hold_pc;

  logic              req;
  logic              busy_int;
  logic              xfer;
  logic              push;
  logic              pop;
  logic              not_full;
  logic              has_data;

  assign redir_al = bus.redirect_pc & ~ADDR_W'(3);
  assign not_full = (count < CNT_W'(DEPTH));
  assign has_data = (count != '0);
  assign xfer     = req && bus.mem_ack;

  // A redirect flushes the buffer, so it suppresses both push and pop that cycle.
  assign push = (state_q == FETCH) && xfer && !bus.redirect;
  assign pop  = has_data && bus.instr_ready && !bus.redirect;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: if (bus.redirect && req && !bus.mem_ack) state_d = KILL;
      KILL:  if (bus.mem_ack)                         state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // FSM: outputs. In KILL the abandoned request stays raised until acked.
  always_comb begin
    req      = 1'b0;
    busy_int = 1'b0;
    unique case (state_q)
      FETCH: req = run_q && not_full;
      KILL: begin
        req      = 1'b1;
        busy_int = 1'b1;
      end
      default: req = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch address: fetch_pc is only moved by an ack or a redirect, which keeps
  // a raised request stable; in KILL it still names the killed address.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      tgt_pc   <= '0;
    end else if (state_q == KILL) begin
      if (bus.redirect) tgt_pc <= redir_al;
      if (bus.mem_ack)  fetch_pc <= bus.redirect ? redir_al : tgt_pc;
    end else if (bus.redirect) begin
      if (req && !bus.mem_ack) tgt_pc   <= redir_al;
      else                     fetch_pc <= redir_al;
    end else if (xfer) begin
      fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch buffer control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage carries no reset; entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= bus.mem_rdata;
      buf_pc[wr_ptr]    <= fetch_pc;
    end
  end

  // Shadow of the displayed head so the outputs hold once the buffer empties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (has_data) begin
      hold_instr <= buf_instr[rd_ptr];
      hold_pc    <= buf_pc[rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  assign bus.mem_req     = req;
  assign bus.mem_addr    = fetch_pc;
  assign bus.busy        = busy_int;
  assign bus.instr_valid = has_data;
  assign bus.instr_out   = has_data ? buf_instr[rd_ptr] : hold_instr;
  assign bus.instr_pc    = has_data ? buf_pc[rd_ptr]    : hold_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios followed by random
// ack/ready/redirect traffic checked against the architectural PC stream.
module tb_instr_fetch_unit;

  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always_comb bus.mem_rdata = mem_word(bus.mem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pops  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // The consumer must see a contiguous word stream starting at the restart PC.
  task automatic load_stream(input logic [31:0] start);
    logic [31:0] a;
    sb.delete();
    for (int i = 0; i < 256; i++) begin
      a = start + 32'(4 * i);
      sb.push_back('{pc: a, data: mem_word(a)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    load_stream(pc & ~32'h3);
  endtask

  // Monitor: protocol checks and scoreboard pops on every accepted instruction.
  logic        prev_ok = 1'b0;
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok && prev_req && !prev_ack) begin
        check("req_hold", bus.mem_req, 1);
        check("addr_hold", bus.mem_addr, prev_addr);
      end
      if (bus.mem_req) check("addr_align", bus.mem_addr[1:0], 0);
      if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_empty: got pc %0h, expected no instruction", bus.instr_pc);
        end else begin
          e = sb.pop_front();
          check("pop_pc", bus.instr_pc, e.pc);
          check("pop_data", bus.instr_out, e.data);
          n_pops++;
        end
      end
      prev_ok   = 1'b1;
      prev_req  = bus.mem_req;
      prev_ack  = bus.mem_ack;
      prev_addr = bus.mem_addr;
    end
  end

  int since_redir;
  int pops_start;

  initial begin
    bus.mem_ack     = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    load_stream(RST_PC);

    // Reset release and streaming at full rate
    repeat (2) @(posedge clk);
    #2;
    reset_n         = 1'b1;
    bus.mem_ack     = 1'b1;
    bus.instr_ready = 1'b1;
    sample();
    check("rst_req", bus.mem_req, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_out", bus.instr_out, 0);
    check("rst_pc", bus.instr_pc, 0);
    check("rst_busy", bus.busy, 0);
    sample();
    check("s1_req", bus.mem_req, 1);
    check("s1_addr", bus.mem_addr, 32'h100);
    check("s1_valid", bus.instr_valid, 0);
    sample();
    check("s2_addr", bus.mem_addr, 32'h104);
    check("s2_valid", bus.instr_valid, 1);
    check("s2_pc", bus.instr_pc, 32'h100);
    sample();
    check("s3_addr", bus.mem_addr, 32'h108);
    check("s3_pc", bus.instr_pc, 32'h104);

    // Full buffer: restart at 0x100 with the consumer stalled
    step();
    bus.instr_ready = 1'b0;
    do_redirect(32'h100);
    sample();
    step();
    bus.redirect = 1'b0;
    sample();
    check("f_addr0", bus.mem_addr, 32'h100);
    check("f_valid0", bus.instr_valid, 0);
    step();
    sample();
    check("f_addr1", bus.mem_addr, 32'h104);
    check("f_pc1", bus.instr_pc, 32'h100);
    step();
    sample();
    check("f_full_req", bus.mem_req, 0);
    check("f_full_pc", bus.instr_pc, 32'h100);
    step();
    sample();
    check("f_full_req2", bus.mem_req, 0);
    step();
    bus.instr_ready = 1'b1;
    sample();
    step();
    bus.instr_ready = 1'b0;
    bus.mem_ack     = 1'b0;
    sample();
    check("f_rearm_req", bus.mem_req, 1);
    check("f_rearm_addr", bus.mem_addr, 32'h108);
    check("f_rearm_pc", bus.instr_pc, 32'h104);

    // Ack withheld for three cycles
    step();
    bus.instr_ready = 1'b1;
    sample();
    check("w_addr2", bus.mem_addr, 32'h108);
    step();
    bus.instr_ready = 1'b0;
    sample();
    check("w_addr3", bus.mem_addr, 32'h108);
    check("w_valid3", bus.instr_valid, 0);
    step();
    bus.mem_ack = 1'b1;
    sample();
    check("w_ack_valid", bus.instr_valid, 0);
    step();
    bus.mem_ack = 1'b0;
    sample();
    check("w_entry_valid", bus.instr_valid, 1);
    check("w_entry_pc", bus.instr_pc, 32'h108);
    check("w_next_addr", bus.mem_addr, 32'h10C);

    // Redirect while a request is pending, then a second one during the drain
    step();
    do_redirect(32'h200);
    sample();
    step();
    bus.redirect = 1'b0;
    sample();
    check("k_busy0", bus.busy, 1);
    check("k_addr0", bus.mem_addr, 32'h10C);
    check("k_valid0", bus.instr_valid, 0);
    step();
    do_redirect(32'h300);
    sample();
    check("k_busy1", bus.busy, 1);
    step();
    bus.redirect = 1'b0;
    sample();
    check("k_busy2", bus.busy, 1);
    check("k_addr2", bus.mem_addr, 32'h10C);
    step();
    bus.mem_ack = 1'b1;
    sample();
    check("k_busy3", bus.busy, 1);
    step();
    bus.instr_ready = 1'b1;
    sample();
    check("k_busy_end", bus.busy, 0);
    check("k_resume", bus.mem_addr, 32'h300);
    check("k_valid_end", bus.instr_valid, 0);
    step();
    sample();
    check("k_first_pc", bus.instr_pc, 32'h300);

    // Redirect in the same cycle as an ack, with an entry buffered
    step();
    check("a_pre_valid", bus.instr_valid, 1);
    check("a_pre_req", bus.mem_req, 1);
    bus.instr_ready = 1'b0;
    do_redirect(32'h400);
    sample();
    step();
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b1;
    sample();
    check("a_valid", bus.instr_valid, 0);
    check("a_addr", bus.mem_addr, 32'h400);
    step();
    sample();
    check("a_first_pc", bus.instr_pc, 32'h400);

    // Asynchronous reset between clock edges
    step();
    step();
    #2;
    reset_n = 1'b0;
    load_stream(RST_PC);
    #1;
    check("ar_req", bus.mem_req, 0);
    check("ar_valid", bus.instr_valid, 0);
    check("ar_out", bus.instr_out, 0);
    check("ar_pc", bus.instr_pc, 0);
    check("ar_busy", bus.busy, 0);
    sample();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    sample();
    sample();
    check("ar_restart", bus.mem_addr, RST_PC);
    check("ar_restart_req", bus.mem_req, 1);

    // Random traffic
    since_redir = 0;
    pops_start  = n_pops;
    for (int c = 0; c < 3000; c++) begin
      step();
      bus.redirect    = 1'b0;
      bus.mem_ack     = ($urandom_range(0, 99) < 70);
      bus.instr_ready = ($urandom_range(0, 99) < 70);
      since_redir++;
      if (($urandom_range(0, 99) < 3) || since_redir > 150) begin
        if ($urandom_range(0, 9) == 0) do_redirect(32'hFFFF_FFF0 | $urandom_range(0, 15));
        else                           do_redirect($urandom());
        since_redir = 0;
      end
    end
    step();
    bus.redirect = 1'b0;
    sample();

    n_tests++;
    if (n_pops - pops_start < 300) begin
      n_fail++;
      $display("FAIL rand_throughput: got %0d pops, expected at least 300", n_pops - pops_start);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
